// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR ADC controller and its synchronizer.
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } sar_state_e;

    localparam int unsigned SYNC_DEPTH = 2;

    // Bits needed to hold values 0..n-1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Handshake and analog-facing signals of the SAR controller.
interface sar_adc_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             cmp_in;
    logic             sample;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        input  start, cmp_in,
        output sample, dac_code, busy, done, result
    );

    modport slave (
        output start, cmp_in,
        input  sample, dac_code, busy, done, result
    );
endinterface

// File: rtl/sar_sync2.sv
// Generic multi-flop synchronizer, async active-high reset to 0.
module sar_sync2
    import sar_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [SYNC_DEPTH-1:0][W-1:0] stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage <= {stage[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = stage[SYNC_DEPTH-1];
endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: samples, resolves one bit per settle
// window MSB first, and publishes the code with a one-cycle done pulse.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    sar_adc_ctrl_if.master bus
);
    localparam int unsigned MAX_CNT = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = (clog2(MAX_CNT) > 0) ? clog2(MAX_CNT) : 1;
    localparam int unsigned IDX_W   = clog2(WIDTH);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_SAMPLE  = ST_SAMPLE;
    localparam logic [1:0] S_CONVERT = ST_CONVERT;
    localparam logic [1:0] S_DONE    = ST_DONE;

    // Decision must see the synchronized comparator after the DAC has settled.
    if (SETTLE_CYCLES < 3) begin : g_chk_settle
        $error("SETTLE_CYCLES must be >= 3");
    end
    if (SAMPLE_CYCLES < 1) begin : g_chk_sample
        $error("SAMPLE_CYCLES must be >= 1");
    end
    if (WIDTH < 4 || WIDTH > 12) begin : g_chk_width
        $error("WIDTH must be in 4..12");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic             sample_q, sample_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cmp_s;

    sar_sync2 #(.W(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.cmp_in),
        .q   (cmp_s)
    );

    // Next state plus registered-output values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        trial_d  = trial_q;
        sample_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        dac_d    = '0;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_SAMPLE;
                    cnt_d    = '0;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SAMPLE: begin
                sample_d = 1'b1;
                busy_d   = 1'b1;
                if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
                    state_d         = S_CONVERT;
                    cnt_d           = '0;
                    idx_d           = IDX_W'(WIDTH - 1);
                    trial_d         = '0;
                    sample_d        = 1'b0;
                    dac_d[WIDTH-1]  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_CONVERT: begin
                busy_d = 1'b1;
                dac_d  = trial_q | (WIDTH'(1) << idx_q);
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    trial_d[idx_q] = cmp_s;
                    cnt_d          = '0;
                    if (idx_q == '0) begin
                        state_d  = S_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        dac_d    = '0;
                        result_d = trial_d;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                        dac_d = trial_d | (WIDTH'(1) << idx_d);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            trial_q  <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dac_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            trial_q  <= trial_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dac_q    <= dac_d;
            result_q <= result_d;
        end
    end

    assign bus.sample   = sample_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.dac_code = dac_q;
    assign bus.result   = result_q;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl with an ideal comparator model on the DAC.
module tb_sar_adc_ctrl;
    localparam int unsigned W  = 8;
    localparam int unsigned SC = 2;
    localparam int unsigned ST = 4;
    localparam int CONV_CYC    = SC + W * ST + 1;

    typedef struct packed {
        logic         sample;
        logic [W-1:0] dac;
    } trace_t;

    logic clk = 1'b0;
    logic rst;

    sar_adc_ctrl_if #(.WIDTH(W)) bus ();

    sar_adc_ctrl #(
        .WIDTH         (W),
        .SAMPLE_CYCLES (SC),
        .SETTLE_CYCLES (ST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    logic [W-1:0] vin = '0;
    bit           jitter_en = 1'b0;
    trace_t       trace_q[$];
    logic [W-1:0] res_q[$];
    int           acc_q[$];
    int           cyc = 0;
    int           model_left = 0;
    int           n_acc = 0;
    int           n_done = 0;
    logic [W-1:0] hold_exp = '0;

    // Expected per-cycle trace: sample window at code 0, then each trial code
    // held for a settle window, found by plain binary search on vin.
    task automatic push_expect(input logic [W-1:0] v);
        int code;
        code = 0;
        repeat (SC) trace_q.push_back(trace_t'{sample: 1'b1, dac: '0});
        for (int b = W - 1; b >= 0; b--) begin
            int t;
            t = code + (1 << b);
            repeat (ST) trace_q.push_back(trace_t'{sample: 1'b0, dac: W'(t)});
            if (int'(v) >= t) code = t;
        end
        res_q.push_back(v);
        acc_q.push_back(cyc);
        n_acc++;
    endtask

    // Protocol model: a start seen while idle or on the done cycle begins a conversion.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            model_left = 0;
        end else if (model_left <= 1 && bus.start === 1'b1) begin
            push_expect(vin);
            model_left = CONV_CYC;
        end else if (model_left > 0) begin
            model_left = model_left - 1;
        end
    end

    // Comparator: ideal decision, optionally noisy right after each DAC step.
    logic [W-1:0] prev_dac;
    time          t_chg;
    initial begin
        bus.cmp_in = 1'b0;
        prev_dac   = '0;
        t_chg      = 0;
        forever begin
            #1;
            if (bus.dac_code !== prev_dac) begin
                prev_dac = bus.dac_code;
                t_chg    = $time;
            end
            if (jitter_en && ($time - t_chg) < 12)
                bus.cmp_in = 1'($urandom_range(0, 1));
            else
                bus.cmp_in = (vin >= bus.dac_code);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT is busy or signals done.
    trace_t mon_e;
    int     mon_a;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.busy) begin
                if (trace_q.size() == 0) begin
                    chk(1'b0, "unexpected_busy", 1, 0);
                end else begin
                    mon_e = trace_q.pop_front();
                    chk({bus.sample, bus.dac_code} == mon_e, "trace_sample_dac",
                        {bus.sample, bus.dac_code}, mon_e);
                end
                chk(bus.done == 1'b0, "done_while_busy", bus.done, 0);
            end else begin
                chk(bus.sample == 1'b0 && bus.dac_code == '0, "idle_sample_dac",
                    {bus.sample, bus.dac_code}, 0);
            end
            if (bus.done) begin
                n_done++;
                if (res_q.size() == 0) begin
                    chk(1'b0, "unexpected_done", 1, 0);
                end else begin
                    hold_exp = res_q.pop_front();
                    mon_a    = acc_q.pop_front();
                    chk(cyc - mon_a == CONV_CYC - 1, "done_latency", cyc - mon_a + 1, CONV_CYC);
                end
            end
            chk(bus.result == hold_exp, "result", bus.result, hold_exp);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((model_left != 0 || trace_q.size() != 0 || res_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk(1'b0, "idle_timeout", n, budget);
    endtask

    task automatic convert(input logic [W-1:0] v);
        vin       = v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_idle(4 * CONV_CYC);
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        trace_q.delete();
        res_q.delete();
        acc_q.delete();
        hold_exp   = '0;
        model_left = 0;
        #1;
        chk({bus.sample, bus.busy, bus.done, bus.dac_code, bus.result} == '0, "reset_outputs",
            {bus.sample, bus.busy, bus.done, bus.dac_code, bus.result}, 0);
    endtask

    initial begin
        int d0;
        int a0;
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (2) tick();
        assert_reset();
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Directed codes, including both ends of the range.
        convert(8'hA5);
        convert(8'h00);
        convert(8'hFF);

        // Start held high: back-to-back conversions.
        vin       = 8'h3C;
        d0        = n_done;
        a0        = n_acc;
        bus.start = 1'b1;
        repeat (3 * CONV_CYC + 5) tick();
        bus.start = 1'b0;
        wait_idle(4 * CONV_CYC);
        chk(n_done - d0 >= 3, "b2b_done_count", n_done - d0, 3);
        chk(n_done - d0 == n_acc - a0, "b2b_done_vs_accept", n_done - d0, n_acc - a0);

        // Extra start pulses while busy must not add conversions.
        vin       = 8'h96;
        d0        = n_done;
        bus.start = 1'b1;
        tick();
        while (model_left > 2) begin
            bus.start = 1'($urandom_range(0, 1));
            tick();
        end
        bus.start = 1'b0;
        wait_idle(4 * CONV_CYC);
        chk(n_done - d0 == 1, "busy_start_ignored", n_done - d0, 1);

        // Reset mid-conversion discards the partial result.
        vin       = 8'h5A;
        d0        = n_done;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (14) tick();
        @(posedge clk);
        #3;
        assert_reset();
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        chk(n_done == d0, "no_done_after_reset", n_done - d0, 0);
        convert(8'h5A);
        chk(n_done - d0 == 1, "fresh_after_reset", n_done - d0, 1);

        // Asynchronous comparator noise after each DAC step.
        jitter_en = 1'b1;
        convert(8'h81);
        convert(8'h7E);
        jitter_en = 1'b0;

        // Random codes with random idle gaps.
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            convert(W'($urandom));
        end

        repeat (3) tick();
        chk(trace_q.size() == 0 && res_q.size() == 0, "scoreboard_drained",
            trace_q.size() + res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Digital successive-approximation controller that sits directly downstream of the analog comparator in the aicd playground macro. It also sits directly upstream of the on-chip capacitive/R-2R DAC.
- Samples the comparator decision bit, drives a trial DAC code, and resolves one bit per step, MSB first.
- Presents the final code and a one-cycle completion pulse to the digital readout (uo_out / uio).

Parameters:
WIDTH, 8, result and DAC code width in bits (4..12)
SAMPLE_CYCLES, 2, cycles the track/hold switch stays closed (>=1)
SETTLE_CYCLES, 4, cycles per bit trial; DAC settling plus 2-flop sync latency (>=3, enforced by elaboration check)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  conversion request, level-sampled in IDLE/DONE only
cmp_in  in  1  raw comparator output, asynchronous to clk; 1 = Vin >= Vdac
sample  out  1  track/hold switch enable to analog front end
dac_code  out  WIDTH  trial code to DAC
busy  out  1  high from first SAMPLE cycle through last CONVERT cycle
done  out  1  one-cycle pulse when result updates
result  out  WIDTH  last completed conversion, held until next done

Behaviour:
- Reset (async assert, sync deassert by the top level): state=IDLE. sample=0, dac_code=0, busy=0, done=0, result=0, sync flops=0, counters=0.
- cmp_in passes through a 2-flop synchronizer (cmp_s). Only cmp_s is used.
- States: IDLE, SAMPLE, CONVERT, DONE.
- IDLE:
  - start=1 at edge E0 -> SAMPLE.
  - Otherwise stay.
- SAMPLE:
  - sample=1, busy=1, dac_code=0.
  - Counter runs SAMPLE_CYCLES cycles, then -> CONVERT with bit index i=WIDTH-1 and trial register trial=0.
- CONVERT:
  - sample=0, busy=1, dac_code = trial | (1<<i).
  - Settle counter counts SETTLE_CYCLES cycles.
  - On the last cycle, bit i of trial takes cmp_s (1 = keep, 0 = clear).
  - If i==0 -> DONE; else i decrements and the settle counter reloads.
  - dac_code changes only at bit boundaries; no glitch cycles between trials.
- DONE (exactly one cycle):
  - done=1, result <= final trial (registered on entry), busy=0, dac_code=0.
  - start=1 in this cycle -> SAMPLE directly (back-to-back); else -> IDLE.
- Latency: done high in the cycle after edge E0 + SAMPLE_CYCLES + WIDTH*SETTLE_CYCLES + 1. With defaults that is 35 edges.
- start is ignored in SAMPLE and CONVERT. No queuing.
- result changes only on the done cycle. It stays stable through subsequent conversions until their done.
- rst asserted mid-conversion: immediate return to reset values, and the partial result is discarded.
- Boundary codes:
  - Vin below LSB -> result=0.
  - Vin at or above full scale -> result = all ones.
  - No overflow path exists: trial is WIDTH bits, and the index never underflows because the exit is on i==0.

Decomposition:
- Shared package sar_pkg holds:
  - state enum (IDLE, SAMPLE, CONVERT, DONE, 2-bit);
  - localparam for sync depth (2);
  - function clog2 for counter widths.
- One sub-module, sar_sync2: generic 2-flop synchronizer with async active-high reset to 0. It is reused by other playground blocks.
- Counters (sample/settle shared, bit index) live in sar_adc_ctrl.

Test Plan:
- Bench comparator model: cmp_in = (vin >= dac_code), updated combinationally from dac_code. All cases use defaults (WIDTH=8, SAMPLE_CYCLES=2, SETTLE_CYCLES=4).
- vin=0xA5, start pulse at E0 -> sample high for 2 cycles. dac_code sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5, each held 4 cycles. done at E0+35, result=0xA5, busy low on the done cycle.
- vin=0x00 then vin=0xFF -> result=0x00 and 0xFF respectively. dac_code never exceeds 0xFF and never glitches between steps.
- start held high continuously with vin=0x3C -> back-to-back conversions with done every 35 cycles, each result=0x3C. Extra start pulses during busy produce no extra done.
- rst asserted at cycle 15 of a conversion (vin=0x5A) -> all outputs 0 asynchronously and no done. A fresh start then yields 0x5A and previous result=0 until that done.
- cmp_in toggled asynchronously (random sub-cycle offsets) with vin=0x81 -> result still 0x81. The decision is taken only from the synchronized value on the last settle cycle of each bit.
